// File: rtl/p1_sprite_fetch.sv
// Player-1 sprite reader: fetches one 16-bit bitmap row per scanline during hblank,
// then streams it out as a scaled, optionally mirrored per-pixel opaque flag.
module p1_sprite_fetch #(
    parameter int unsigned SCALE_LOG2 = 2,
    parameter int unsigned ANIM_DIV   = 8
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_vsync_pulse,
    input  logic        i_hblank_pulse,
    input  logic [9:0]  i_next_y,
    input  logic [9:0]  i_pix_x,
    input  logic        i_video_on,
    input  logic [9:0]  i_pos_x,
    input  logic [9:0]  i_pos_y,
    input  logic [2:0]  i_action,
    input  logic        i_facing,
    input  logic        i_anim_en,
    output logic [9:0]  o_rom_addr,
    input  logic [15:0] i_rom_bitmap,
    output logic [1:0]  o_frame,
    output logic        o_pix_opaque,
    output logic        o_fetch_busy
);

    localparam logic [7:0] DIV_LAST = 8'(ANIM_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_CAPT
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [2:0]  r_action_l;
    logic        r_facing_l;
    logic [7:0]  r_div;
    logic [1:0]  r_frame;
    logic [15:0] r_linebuf;
    logic        r_row_valid;
    logic [9:0]  r_rom_addr;
    logic        r_pix_opaque;

    logic [7:0]  w_div_nxt;
    logic [1:0]  w_frame_nxt;
    logic [2:0]  w_action_eff;
    logic [9:0]  w_dy;
    logic [9:0]  w_row_full;
    logic        w_row_hit;
    logic [9:0]  w_fetch_addr;
    logic        w_start;
    logic        w_miss;
    logic        w_capture;
    logic        w_busy;
    logic [9:0]  w_dx;
    logic [9:0]  w_col_full;
    logic        w_in_win;
    logic [3:0]  w_bit_idx;

    // Frame-start latch: an action change restarts the animation from frame 0.
    always_comb begin
        w_div_nxt   = r_div;
        w_frame_nxt = r_frame;
        if (i_vsync_pulse) begin
            if (i_action != r_action_l) begin
                w_div_nxt   = '0;
                w_frame_nxt = '0;
            end else if (i_anim_en) begin
                if (r_div == DIV_LAST) begin
                    w_div_nxt   = '0;
                    w_frame_nxt = r_frame + 2'd1;
                end else begin
                    w_div_nxt   = r_div + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_action_l <= '0;
            r_facing_l <= 1'b0;
            r_div      <= '0;
            r_frame    <= '0;
        end else begin
            r_div   <= w_div_nxt;
            r_frame <= w_frame_nxt;
            if (i_vsync_pulse) begin
                r_action_l <= i_action;
                r_facing_l <= i_facing;
            end
        end
    end

    // A fetch coinciding with vsync must see the freshly latched action and frame.
    assign w_action_eff = i_vsync_pulse ? i_action : r_action_l;

    assign w_dy         = i_next_y - i_pos_y;
    assign w_row_full   = w_dy >> SCALE_LOG2;
    assign w_row_hit    = (i_next_y >= i_pos_y) && (w_row_full < 10'd16);
    assign w_fetch_addr = {w_row_full[3:0], w_action_eff, 1'b0, w_frame_nxt};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (i_hblank_pulse && w_row_hit) w_state_nxt = S_ADDR;
            S_ADDR:  w_state_nxt = S_CAPT;
            S_CAPT:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy    = (r_state != S_IDLE);
        w_start   = (r_state == S_IDLE) && i_hblank_pulse && w_row_hit;
        w_miss    = (r_state == S_IDLE) && i_hblank_pulse && !w_row_hit;
        w_capture = (r_state == S_CAPT);
    end

    // The ROM registers the address on the ADDR edge, so data is ready in CAPT.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rom_addr  <= '0;
            r_linebuf   <= '1;
            r_row_valid <= 1'b0;
        end else begin
            if (w_start) begin
                r_rom_addr <= w_fetch_addr;
            end
            if (w_miss) begin
                r_row_valid <= 1'b0;
            end
            if (w_capture) begin
                r_linebuf   <= i_rom_bitmap;
                r_row_valid <= 1'b1;
            end
        end
    end

    assign w_dx       = i_pix_x - i_pos_x;
    assign w_col_full = w_dx >> SCALE_LOG2;
    assign w_in_win   = i_video_on && (i_pix_x >= i_pos_x) && (w_col_full < 10'd16);
    assign w_bit_idx  = r_facing_l ? w_col_full[3:0] : (4'd15 - w_col_full[3:0]);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pix_opaque <= 1'b0;
        end else begin
            r_pix_opaque <= w_in_win & r_row_valid & ~r_linebuf[w_bit_idx];
        end
    end

    assign o_rom_addr   = r_rom_addr;
    assign o_frame      = r_frame;
    assign o_pix_opaque = r_pix_opaque;
    assign o_fetch_busy = w_busy;

endmodule
